// File: rtl/dma_init_if.sv
// Init request/completion pair between the init sequencer and the DMA AXI-Lite write master.
// Handshake: the master holds a one-hot slaveInit until the slave returns an identical slaveFinInit; a zero cycle always separates requests.
interface dma_init_if #(
  parameter int N = 8
) ();
  logic [N-1:0] slaveInit;
  logic [N-1:0] slaveFinInit;

  modport master (output slaveInit, input slaveFinInit);
  modport slave  (input slaveInit, output slaveFinInit);
endinterface

// File: rtl/dma_init_sequencer.sv
// Walks the DMA init tasks in index order, one one-hot request at a time, with skip mask,
// per-task timeout, abort, completion/error reporting and a saturating cycle profile.
module dma_init_sequencer #(
  parameter int DMA_INIT_TASK_CNT = 8,
  parameter int IDX_WIDTH         = 4,
  parameter int TIMEOUT_WIDTH     = 16,
  parameter int PROFILE_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [DMA_INIT_TASK_CNT-1:0] taskMask,
  input  logic [TIMEOUT_WIDTH-1:0]     timeoutLimit,
  dma_init_if.master                   init_if,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   errCode,
  output logic [IDX_WIDTH-1:0]         errTaskIdx,
  output logic [PROFILE_WIDTH-1:0]     profileCycles,
  output logic [2:0]                   state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DMA_INIT_TASK_CNT);

  state_e                         state_q, state_d;
  logic [IDX_WIDTH-1:0]           idx_q, idx_d;
  logic [DMA_INIT_TASK_CNT-1:0]   mask_q, mask_d;
  logic [TIMEOUT_WIDTH-1:0]       tlim_q, tlim_d;
  logic [TIMEOUT_WIDTH-1:0]       tcnt_q, tcnt_d;
  logic [DMA_INIT_TASK_CNT-1:0]   init_q, init_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic [1:0]                     code_q, code_d;
  logic [IDX_WIDTH-1:0]           eidx_q, eidx_d;
  logic [PROFILE_WIDTH-1:0]       prof_q, prof_d;

  logic [DMA_INIT_TASK_CNT-1:0]   idx_onehot;
  logic                           task_enabled;
  logic                           fin_match;
  logic                           timed_out;

  // Shifting by the terminal index yields zero, so the mask test is safe there too.
  assign idx_onehot   = DMA_INIT_TASK_CNT'(1) << idx_q;
  assign task_enabled = |(mask_q & idx_onehot);
  assign fin_match    = (init_if.slaveFinInit == init_q);
  assign timed_out    = (tlim_q != '0) && (tcnt_q == tlim_q - TIMEOUT_WIDTH'(1)) && !fin_match;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    tlim_d  = tlim_q;
    tcnt_d  = tcnt_q;
    init_d  = init_q;
    err_d   = err_q;
    code_d  = code_q;
    eidx_d  = eidx_q;
    prof_d  = prof_q;

    if ((state_q == S_SCAN || state_q == S_ISSUE) && prof_q != '1) begin
      prof_d = prof_q + PROFILE_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = taskMask;
          tlim_d  = timeoutLimit;
          idx_d   = '0;
          prof_d  = '0;
          err_d   = 1'b0;
          code_d  = 2'b00;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          eidx_d  = idx_q;
          state_d = S_ERROR;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else if (task_enabled) begin
          init_d  = idx_onehot;
          tcnt_d  = '0;
          state_d = S_ISSUE;
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      S_ISSUE: begin
        // Abort is deliberately not looked at here: an in-flight write is never cut.
        if (fin_match) begin
          init_d  = '0;
          idx_d   = idx_q + IDX_WIDTH'(1);
          state_d = S_SCAN;
        end else if (timed_out) begin
          init_d  = '0;
          err_d   = 1'b1;
          code_d  = 2'b01;
          eidx_d  = idx_q;
          state_d = S_ERROR;
        end else begin
          tcnt_d = tcnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SCAN) || (state_d == S_ISSUE) || (state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      tlim_q  <= '0;
      tcnt_q  <= '0;
      init_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      eidx_q  <= '0;
      prof_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      tlim_q  <= tlim_d;
      tcnt_q  <= tcnt_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
      prof_q  <= prof_d;
    end
  end

  assign init_if.slaveInit = init_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = err_q;
  assign errCode           = code_q;
  assign errTaskIdx        = eidx_q;
  assign profileCycles     = prof_q;
  assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_dma_init_sequencer.sv
// Bench for dma_init_sequencer: a responder answers requests after per-task delays and
// a run-level model predicts the issued requests, hold lengths, profile and error outcome.
module tb_dma_init_sequencer;

  localparam int N = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  taskMask;
  logic [15:0] timeoutLimit;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  errCode;
  logic [3:0]  errTaskIdx;
  logic [31:0] profileCycles;
  logic [2:0]  state_dbg;

  dma_init_if #(.N(N)) init_if ();

  dma_init_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .taskMask      (taskMask),
    .timeoutLimit  (timeoutLimit),
    .init_if       (init_if),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .errCode       (errCode),
    .errTaskIdx    (errTaskIdx),
    .profileCycles (profileCycles),
    .state_dbg_o   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder configuration: dly[i] = ISSUE cycles before fin for task i, -1 = never answers.
  int   dly [N];
  logic abort_mode = 1'b0;
  logic junk_mode  = 1'b0;

  // Observed requests
  logic [7:0] got_q[$];
  int         got_len_q[$];
  int         gap_err;
  int         done_cnt;
  logic [7:0] prev_init = '0;
  logic [7:0] cur;

  // Expected outcome
  logic [7:0]  exp_q[$];
  int          exp_len_q[$];
  logic [31:0] exp_prof;
  logic        exp_err;
  logic [1:0]  exp_code;
  logic [3:0]  exp_idx;
  int          exp_done;

  // Responder + monitor, sampling 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    cur = init_if.slaveInit;
    if (cur != 8'h00) begin
      if (cur != prev_init) begin
        if (prev_init != 8'h00) gap_err++;
        got_q.push_back(cur);
        got_len_q.push_back(1);
      end else begin
        got_len_q[got_len_q.size()-1]++;
      end
      begin
        int bi;
        int c;
        bi = 0;
        for (int k = 0; k < N; k++) if (cur[k]) bi = k;
        c = got_len_q[got_len_q.size()-1] - 1;
        if (c == dly[bi])   init_if.slaveFinInit = cur;
        else if (junk_mode) init_if.slaveFinInit = {cur[6:0], cur[7]};
        else                init_if.slaveFinInit = 8'h00;
      end
      if (abort_mode) abort = 1'b1;
    end else begin
      init_if.slaveFinInit = 8'h00;
    end
    if (done) done_cnt++;
    prev_init = cur;
  end

  // Run-level model: one SCAN per evaluated index, d+1 ISSUE cycles per answered task,
  // timeout after tlim ISSUE cycles, abort caught by the SCAN after the first issued task.
  function automatic void model(input logic [7:0] mask, input logic [15:0] tlim,
                                input logic ab_mode);
    logic ab;
    exp_q.delete();
    exp_len_q.delete();
    exp_prof = 0;
    exp_err  = 1'b0;
    exp_code = 2'b00;
    exp_idx  = 4'd0;
    exp_done = 0;
    ab       = 1'b0;
    for (int i = 0; i <= N; i++) begin
      exp_prof++;
      if (ab) begin
        exp_err = 1'b1; exp_code = 2'b10; exp_idx = 4'(i);
        return;
      end
      if (i == N) begin
        exp_done = 1;
        return;
      end
      if (mask[i]) begin
        exp_q.push_back(8'(1 << i));
        if (tlim != 0 && (dly[i] < 0 || dly[i] >= int'(tlim))) begin
          exp_len_q.push_back(int'(tlim));
          exp_prof += 32'(tlim);
          exp_err = 1'b1; exp_code = 2'b01; exp_idx = 4'(i);
          return;
        end
        exp_len_q.push_back(dly[i] + 1);
        exp_prof += 32'(dly[i] + 1);
        if (ab_mode) ab = 1'b1;
      end
    end
  endfunction

  // Driver: start one run, wait for it to end, then check it against the model.
  task automatic run_and_check(input string name, input logic [7:0] mask,
                               input logic [15:0] tlim, input logic ab_mode,
                               input logic junk, input logic poke);
    int k;
    logic finished;
    model(mask, tlim, ab_mode);
    @(negedge clk);
    got_q.delete();
    got_len_q.delete();
    gap_err    = 0;
    done_cnt   = 0;
    abort_mode = ab_mode;
    junk_mode  = junk;
    start        = 1'b1;
    taskMask     = mask;
    timeoutLimit = tlim;
    @(negedge clk);
    start = 1'b0;
    finished = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (poke && k == 2) begin
        start    = 1'b1;
        taskMask = ~mask;
      end
      if (poke && k == 3) begin
        start    = 1'b0;
        taskMask = mask;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s run_end: busy still %b after 3000 cycles, required 0", name, busy);
    end
    @(negedge clk);
    @(negedge clk);
    abort_mode = 1'b0;
    junk_mode  = 1'b0;

    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s req_count: got %0d requests, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s req_value[%0d]: got %h, required %h", name, i, got_q[i], exp_q[i]);
      end
      checks++;
      if (got_len_q[i] != exp_len_q[i]) begin
        errors++;
        $display("FAIL %s req_hold[%0d]: got %0d cycles, required %0d", name, i, got_len_q[i], exp_len_q[i]);
      end
    end
    checks++;
    if (gap_err != 0) begin
      errors++;
      $display("FAIL %s zero_gap: got %0d back-to-back requests, required 0", name, gap_err);
    end
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d, required %0d", name, done_cnt, exp_done);
    end
    checks++;
    if (error !== exp_err) begin
      errors++;
      $display("FAIL %s error: got %b, required %b", name, error, exp_err);
    end
    checks++;
    if (errCode !== exp_code) begin
      errors++;
      $display("FAIL %s errCode: got %b, required %b", name, errCode, exp_code);
    end
    if (exp_err) begin
      checks++;
      if (errTaskIdx !== exp_idx) begin
        errors++;
        $display("FAIL %s errTaskIdx: got %0d, required %0d", name, errTaskIdx, exp_idx);
      end
    end
    checks++;
    if (profileCycles !== exp_prof) begin
      errors++;
      $display("FAIL %s profileCycles: got %0d, required %0d", name, profileCycles, exp_prof);
    end
    checks++;
    if (init_if.slaveInit !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_outputs: slaveInit=%h busy=%b, required 00 and 0", name, init_if.slaveInit, busy);
    end
    abort = 1'b0;
  endtask

  task automatic set_dly(input int v);
    for (int i = 0; i < N; i++) dly[i] = v;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (init_if.slaveInit !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        errCode !== 2'b00 || errTaskIdx !== 4'd0 || profileCycles !== 32'd0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: init=%h busy=%b done=%b err=%b code=%b idx=%0d prof=%0d st=%0d, required all zero",
               init_if.slaveInit, busy, done, error, errCode, errTaskIdx, profileCycles, state_dbg);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_fast();
    set_dly(0);
    run_and_check("all_d0", 8'hFF, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_all_slow();
    set_dly(3);
    run_and_check("all_d3", 8'hFF, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sparse();
    set_dly(0);
    run_and_check("mask_05", 8'h05, 16'd0, 1'b0, 1'b0, 1'b0);
    run_and_check("mask_00", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    set_dly(0);
    dly[2] = -1;
    run_and_check("timeout", 8'hFF, 16'd5, 1'b0, 1'b0, 1'b0);
    dly[2] = 4;
    run_and_check("timeout_edge", 8'hFF, 16'd5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    set_dly(2);
    run_and_check("abort", 8'hFF, 16'd0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int k;
    set_dly(0);
    dly[3] = -1;
    @(negedge clk);
    start        = 1'b1;
    taskMask     = 8'hFF;
    timeoutLimit = 16'd0;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (init_if.slaveInit == 8'h08) break;
      @(negedge clk);
    end
    checks++;
    if (init_if.slaveInit !== 8'h08) begin
      errors++;
      $display("FAIL reset_mid_run reach_task3: slaveInit=%h, required 08", init_if.slaveInit);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (init_if.slaveInit !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run drop: slaveInit=%h busy=%b, required 00 and 0", init_if.slaveInit, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (init_if.slaveInit !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run hold: slaveInit=%h busy=%b, required 00 and 0", init_if.slaveInit, busy);
    end
    reset = 1'b1;
    set_dly(0);
    run_and_check("replay", 8'hFF, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      logic [7:0]  m;
      logic [15:0] t;
      logic        ab;
      logic        jk;
      m  = 8'($urandom_range(0, 255));
      t  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      ab = ($urandom_range(0, 3) == 0);
      jk = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N; i++) begin
        dly[i] = $urandom_range(0, 5);
        if (t != 0 && $urandom_range(0, 5) == 0) dly[i] = -1;
      end
      run_and_check($sformatf("random%0d", r), m, t, ab, jk, ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    taskMask     = 8'h00;
    timeoutLimit = 16'd0;
    init_if.slaveFinInit = 8'h00;
    set_dly(0);
    test_reset();
    test_all_fast();
    test_all_slow();
    test_sparse();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
